// File: rtl/inst_rom_arbiter.sv
// Purpose: shares a single-ported, registered-read instruction ROM between IF and LS requesters.
// Latency: grant is combinational and the response follows exactly 1 cycle later; one grant per cycle, fully pipelined.
// Backpressure: a requester holds req until it sees gnt; LS has priority, and IF wins after STARVE_MAX denied cycles.
module inst_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_err_o,
  // load/debug read port
  input  logic              ls_req_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic              ls_err_o,
  // ROM side
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  logic [CNT_W-1:0]  starve_cnt;
  logic              starve;
  logic              gnt_if;
  logic              gnt_ls;
  logic              any_gnt;
  logic              misaligned;
  logic [ADDR_W-1:0] win_addr;
  owner_t            winner;

  logic              rsp_vld;
  logic              rsp_err;
  owner_t            rsp_own;

  // IF has been denied long enough that it now takes priority over LS.
  assign starve = (starve_cnt == CNT_MAX);

  // Arbitration: at most one grant per cycle, and no grants while in reset.
  always_comb begin
    gnt_if     = 1'b0;
    gnt_ls     = 1'b0;
    if (rst_n) begin
      if (if_req_i && (starve || !ls_req_i)) begin
        gnt_if = 1'b1;
      end else if (ls_req_i) begin
        gnt_ls = 1'b1;
      end
    end
    winner     = gnt_ls ? OWN_LS : OWN_IF;
    win_addr   = gnt_ls ? ls_addr_i : if_addr_i;
    any_gnt    = gnt_if | gnt_ls;
    misaligned = any_gnt && (win_addr[1:0] != 2'b00);
  end

  assign if_gnt_o   = gnt_if;
  assign ls_gnt_o   = gnt_ls;

  // A misaligned grant never touches the ROM; it only produces an error response.
  assign rom_ce_o   = any_gnt & ~misaligned;
  assign rom_addr_o = rom_ce_o ? win_addr : '0;

  // Starvation counter: counts consecutive denied IF cycles and saturates at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (if_req_i && !gnt_if) begin
      if (!starve) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Response tracking: remember who was granted and whether the access faulted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld <= 1'b0;
      rsp_own <= OWN_IF;
      rsp_err <= 1'b0;
    end else begin
      rsp_vld <= any_gnt;
      rsp_own <= winner;
      rsp_err <= misaligned;
    end
  end

  // Route the registered ROM data to the owner of the response; errors return zero data.
  always_comb begin
    if_rvalid_o = rsp_vld && (rsp_own == OWN_IF);
    ls_rvalid_o = rsp_vld && (rsp_own == OWN_LS);
    if_err_o    = if_rvalid_o & rsp_err;
    ls_err_o    = ls_rvalid_o & rsp_err;
    if_rdata_o  = (if_rvalid_o && !rsp_err) ? rom_data_i : '0;
    ls_rdata_o  = (ls_rvalid_o && !rsp_err) ? rom_data_i : '0;
  end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Testbench for inst_rom_arbiter: directed scenarios plus randomized traffic.
// A behavioural model (wait counter, pending-response record, ROM content function)
// predicts every output on every cycle; literal checks pin the model in directed phases.
module tb_inst_rom_arbiter;
  localparam int SM = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, ls_req;
  logic [31:0] if_addr, ls_addr;
  logic        if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err;
  logic [31:0] if_rdata, ls_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr, rom_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
    .ls_req_i(ls_req), .ls_addr_i(ls_addr), .ls_gnt_o(ls_gnt),
    .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata), .ls_err_o(ls_err),
    .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_q)
  );

  // ROM contents: word index n holds 0xC0DE_nnnn.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return {16'hC0DE, a[17:2]};
  endfunction

  // Registered-read ROM stub.
  always @(posedge clk) if (rom_ce) rom_q <= rom_word(rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  int          waited = 0;       // consecutive cycles IF has been refused
  logic        pend_vld = 1'b0;  // a response is due this cycle
  logic        pend_ls  = 1'b0;  // ... and it belongs to LS
  logic        pend_err = 1'b0;
  logic [31:0] pend_addr = '0;

  always @(negedge clk) begin
    logic        e_gif, e_gls, e_mis, e_ce;
    logic [31:0] wa, e_ra, e_data;
    if (!rst_n) begin
      chk("reset_outputs",
          {if_gnt, ls_gnt, rom_ce, if_rvalid, ls_rvalid, if_err, ls_err},
          7'b0);
      chk("reset_data", {if_rdata, ls_rdata}, 64'd0);
      chk("reset_rom_addr", {32'd0, rom_addr}, 64'd0);
      waited   = 0;
      pend_vld = 1'b0;
    end else begin
      e_data = pend_err ? 32'd0 : rom_word(pend_addr);
      chk("if_rvalid", {63'd0, if_rvalid}, {63'd0, pend_vld && !pend_ls});
      chk("ls_rvalid", {63'd0, ls_rvalid}, {63'd0, pend_vld && pend_ls});
      chk("if_err", {63'd0, if_err}, {63'd0, pend_vld && !pend_ls && pend_err});
      chk("ls_err", {63'd0, ls_err}, {63'd0, pend_vld && pend_ls && pend_err});
      chk("if_rdata", {32'd0, if_rdata}, {32'd0, (pend_vld && !pend_ls) ? e_data : 32'd0});
      chk("ls_rdata", {32'd0, ls_rdata}, {32'd0, (pend_vld && pend_ls) ? e_data : 32'd0});

      e_gif = if_req && ((waited >= SM) || !ls_req);
      e_gls = ls_req && !e_gif;
      wa    = e_gif ? if_addr : ls_addr;
      e_mis = (e_gif || e_gls) && (wa % 4 != 0);
      e_ce  = (e_gif || e_gls) && !e_mis;
      e_ra  = e_ce ? wa : 32'd0;
      chk("if_gnt", {63'd0, if_gnt}, {63'd0, e_gif});
      chk("ls_gnt", {63'd0, ls_gnt}, {63'd0, e_gls});
      chk("rom_ce", {63'd0, rom_ce}, {63'd0, e_ce});
      chk("rom_addr", {32'd0, rom_addr}, {32'd0, e_ra});

      pend_vld  = e_gif || e_gls;
      pend_ls   = e_gls;
      pend_err  = e_mis;
      pend_addr = wa;
      if (if_req && !e_gif) waited = (waited + 1 > SM) ? SM : waited + 1;
      else waited = 0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic ir, input logic [31:0] ia, input logic lr, input logic [31:0] la);
    @(posedge clk); #1;
    if_req = ir; if_addr = ia; ls_req = lr; ls_addr = la;
  endtask

  // Test 1 sequence after a reset release: IF fetch of 0x10 returns ROM[4].
  task automatic fetch_after_reset(input string tag);
    drive(1'b1, 32'h10, 1'b0, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_gnt"}, {63'd0, if_gnt}, 64'd1);
    chk({tag, "_rom_addr"}, {32'd0, rom_addr}, 64'h10);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk({tag, "_rvalid"}, {63'd0, if_rvalid}, 64'd1);
    chk({tag, "_rdata"}, {32'd0, if_rdata}, 64'hC0DE_0004);
  endtask

  logic [11:0] if_pat, ls_pat, exp_if_pat;
  logic        ig_s, lg_s;

  initial begin
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b1; ls_addr = 32'h20;
    repeat (3) begin
      @(negedge clk);
      chk("t1_reset_gnts", {61'd0, if_gnt, ls_gnt, rom_ce}, 64'd0);
    end

    // Test 1: first fetch after reset release (release aligned to posedge+1).
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10; ls_req = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_gnt", {63'd0, if_gnt}, 64'd1);
    chk("t1_rom_addr", {32'd0, rom_addr}, 64'h10);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t1_rvalid", {63'd0, if_rvalid}, 64'd1);
    chk("t1_rdata", {32'd0, if_rdata}, 64'hC0DE_0004);

    // Test 2: back-to-back IF fetches 0x0, 0x4, 0x8 with no bubbles.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(1'b1, 32'(4 * k), 1'b0, 32'h0);
      else drive(1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      if (k < 3) chk("t2_gnt", {63'd0, if_gnt}, 64'd1);
      if (k >= 1) chk("t2_rdata", {32'd0, if_rdata}, {32'd0, 16'hC0DE, 16'(k - 1)});
    end

    // Test 3: continuous contention -> LS x4, IF, LS x4, IF, ...
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'h40, 1'b1, 32'h80);
      @(negedge clk);
      if_pat[k] = if_gnt;
      ls_pat[k] = ls_gnt;
    end
    exp_if_pat = 12'b0010_0001_0000;
    chk("t3_if_pattern", {52'd0, if_pat}, {52'd0, exp_if_pat});
    chk("t3_ls_pattern", {52'd0, ls_pat}, {52'd0, ~exp_if_pat});
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);

    // Test 4: misaligned LS read gives an error response and no ROM access.
    drive(1'b0, 32'h0, 1'b1, 32'h6);
    @(negedge clk);
    chk("t4_gnt_ce", {62'd0, ls_gnt, rom_ce}, 64'b10);
    drive(1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t4_rsp", {61'd0, ls_rvalid, ls_err, if_rvalid}, 64'b110);
    chk("t4_rdata", {32'd0, ls_rdata}, 64'd0);

    // Test 5: reset the cycle after an IF grant drops its response.
    drive(1'b1, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t5_gnt", {63'd0, if_gnt}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk("t5_no_rvalid", {63'd0, if_rvalid}, 64'd0);
    @(negedge clk);
    chk("t5_no_rvalid2", {63'd0, if_rvalid}, 64'd0);
    fetch_after_reset("t5");

    // Test 6: idle gaps -> rvalid only after granted cycles.
    for (int k = 0; k < 8; k++) begin
      drive(k % 2 == 0, 32'(8 * k), 1'b0, 32'h0);
      @(negedge clk);
      chk("t6_rvalid", {63'd0, if_rvalid}, {63'd0, k % 2 == 1});
      chk("t6_gnt", {63'd0, if_gnt}, {63'd0, k % 2 == 0});
    end

    // Random traffic: requesters hold req until granted; occasional resets.
    ig_s = 1'b0; lg_s = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      int p;
      p = (k < 2000) ? 50 : 85;
      @(posedge clk); #1;
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; if_req = 1'b0; ls_req = 1'b0;
      end else begin
        rst_n = 1'b1;
        if (!if_req || ig_s) begin
          if_req  = ($urandom_range(0, 99) < p);
          if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          if ($urandom_range(0, 7) == 0) if_addr[1:0] = 2'($urandom_range(1, 3));
        end
        if (!ls_req || lg_s) begin
          ls_req  = ($urandom_range(0, 99) < p);
          ls_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
          if ($urandom_range(0, 7) == 0) ls_addr[1:0] = 2'($urandom_range(1, 3));
        end
      end
      @(negedge clk);
      ig_s = if_gnt; lg_s = ls_gnt;
    end

    drive(1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
